// File: rtl/adder_serial_8bit.sv
// Bit-serial 8-bit adder with carry-in: one bit per clock, LSB first, through a single carry flop.
// Operands are captured on start; sum/co/v/z are registered and held until the next operation completes.
module adder_serial_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic       busy,
  output logic       done,
  output logic [7:0] sum,
  output logic       co,
  output logic       v,
  output logic       z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] ra_q, ra_d;
  logic [7:0] rb_q, rb_d;
  logic       carry_q, carry_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] part_q, part_d;
  logic       sa_q, sa_d;
  logic       sb_q, sb_d;
  logic [7:0] sum_q, sum_d;
  logic       co_q, co_d;
  logic       v_q, v_d;
  logic       z_q, z_d;
  logic       s_bit;

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    s_bit   = ra_q[0] ^ rb_q[0] ^ carry_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = ci;
          cnt_d   = '0;
          part_d  = '0;
          sa_d    = a[7];
          sb_d    = b[7];
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);
        ra_d    = {1'b0, ra_q[7:1]};
        rb_d    = {1'b0, rb_q[7:1]};
        part_d  = {s_bit, part_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        // The edge that shifts in bit 7 also publishes the finished result.
        if (cnt_q == 3'd7) begin
          sum_d   = part_d;
          co_d    = carry_d;
          v_d     = (sa_q == sb_q) && (part_d[7] != sa_q);
          z_d     = (part_d == 8'h00);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign co   = co_q;
  assign v    = v_q;
  assign z    = z_q;

endmodule

// File: tb/tb_adder_serial_8bit.sv
// Directed vector table plus hand-written overlap, reset-abort and back-to-back sequences for adder_serial_8bit.
module tb_adder_serial_8bit;

  logic       clk = 1'b0;
  logic       rst, start, ci;
  logic [7:0] a, b;
  logic       busy, done, co, v, z;
  logic [7:0] sum;

  int errors = 0;
  int checks = 0;

  adder_serial_8bit dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co), .v(v), .z(z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       v;
    logic       z;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation with a one-cycle start; watch up to 15 cycles after acceptance.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                       output int busy_cnt, output int done_cnt, output int lat);
    @(negedge clk);
    a = ta; b = tb; ci = tci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; lat = -1;
    for (int i = 0; i < 15; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = i;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int bc, dc, lat;
    int pulses;
    logic [8:0] full;
    logic [7:0] ra, rb;
    logic       rci;
    logic       ev;

    tbl[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_flags", {sum, co, v, z}, 0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      do_op(tbl[k].a, tbl[k].b, tbl[k].ci, bc, dc, lat);
      check($sformatf("vec%0d_done_count", k), dc, 1);
      check($sformatf("vec%0d_latency", k), lat, 8);
      check($sformatf("vec%0d_busy_cycles", k), bc, 9);
      check($sformatf("vec%0d_sum", k), sum, tbl[k].s);
      check($sformatf("vec%0d_co_v_z", k), {co, v, z}, {tbl[k].co, tbl[k].v, tbl[k].z});
    end

    // Second requests during RUN and DONE are ignored; operand changes after acceptance have no effect.
    @(negedge clk);
    a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) pulses++;
      if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (i == 3) start = 1'b0;
      if (i == 4) check("overlap_sum_held_in_run", sum, tbl[8].s);
      if (i == 5) begin a = 8'h01; b = 8'h02; end
      if (i == 8) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (i == 9) start = 1'b0;
      @(negedge clk);
    end
    check("overlap_single_done", pulses, 1);
    check("overlap_sum", sum, 8'h46);
    check("overlap_co_v_z", {co, v, z}, 3'b000);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_outputs", {sum, co, v, z}, 0);
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", pulses, 0);
    do_op(8'hAA, 8'h55, 1'b1, bc, dc, lat);
    check("after_abort_done", dc, 1);
    check("after_abort_result", {sum, co, v, z}, {8'h00, 1'b1, 1'b0, 1'b1});

    // Reset wins over start at the same edge.
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_priority_busy", busy, 0);
    @(negedge clk);
    check("rst_priority_still_idle", busy, 0);

    // Start held high: an acceptance every 10 cycles, done exactly 9 cycles after each acceptance edge's cycle.
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
      a = ra; b = rb; ci = rci;
      full = {1'b0, ra} + {1'b0, rb} + {8'h00, rci};
      ev = (ra[7] == rb[7]) && (full[7] != ra[7]);
      pulses = 0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (j == 1) begin a = ~ra; b = ~rb; ci = ~rci; end
        if (done) pulses = (j == 8) ? pulses + 1 : pulses + 100;
      end
      check($sformatf("b2b%0d_done_spacing", k), pulses, 1);
      check($sformatf("b2b%0d_result", k), {co, v, z, sum},
            {full[8], ev, full[7:0] == 8'h00, full[7:0]});
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_serial_8bit.md
# adder_serial_8bit

Bit-serial 8-bit adder with carry-in, the additive counterpart to the ALU's ripple-borrow 8-bit subtractor. It processes one bit per clock, LSB first, through a single carry flip-flop. It is used where area matters more than latency, for example in address or accumulator update paths of the miniCPU. Operands are captured on a start handshake, and the result is presented with carry, overflow and zero flags and a one-cycle done pulse.

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  8  augend, captured when start accepted
- b  input  8  addend, captured when start accepted
- ci  input  1  carry-in, captured when start accepted
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse, high in DONE state
- sum  output  8  registered result a + b + ci (mod 256)
- co  output  1  registered carry-out of bit 7
- v  output  1  registered signed overflow: a[7]==b[7] and sum[7]!=a[7]
- z  output  1  registered zero flag: sum==8'h00

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: load shift regs ra<=a, rb<=b, carry<=ci, bit counter cnt<=0, partial result reg cleared; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - s = ra[0]^rb[0]^carry.
  - carry <= majority(ra[0], rb[0], carry).
  - ra, rb shift right by one.
  - s shifts into the MSB of the partial result register.
  - Save the bit-7 operand signs (a[7], b[7]) at load for the overflow computation.
  - cnt increments; when cnt==7, the edge processes the final bit and transitions to DONE.
- Transition RUN->DONE (same edge as bit 7): sum, co, v, z outputs load from the completed result. co is the final carry; v and z are as defined under Interface.
- DONE: done=1 for exactly one cycle; unconditionally return to IDLE.
- start is ignored in RUN and DONE; there is no queueing. a, b and ci may change freely after acceptance.
- sum/co/v/z hold their values until the next operation completes. They do not change during RUN.
- Arithmetic: unsigned 9-bit result {co,sum} = a + b + ci; v is two's-complement overflow of the same add.

## Timing
- Reset (rst=1 at edge): state=IDLE, busy=0, done=0, sum=8'h00, co=0, v=0, z=0, internal regs cleared.
- Reset mid-operation aborts the operation; no done pulse is produced and outputs take reset values.
- Latency: with start accepted at edge E0, RUN occupies edges E1..E8, done is high during the cycle after E8, and the result is valid from E8 onward.
- busy rises after E0 and falls after the DONE cycle (9 cycles high).
- The earliest next acceptance is the edge ending the first IDLE cycle, giving a throughput of one operation per 10 cycles.
- start held high continuously restarts on every IDLE visit.
- rst takes priority over start at the same edge.

## Test plan
- a=8'h3C, b=8'h0F, ci=0, one-cycle start -> after 9 cycles done=1, sum=8'h4B, co=0, v=0, z=0; busy high exactly 9 cycles.
- a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1, v=0, z=1.
- a=8'h7F, b=8'h00, ci=1 -> sum=8'h80, co=0, v=1, z=0; also a=8'h80, b=8'h80, ci=0 -> sum=8'h00, co=1, v=1, z=1.
- Start with a=8'h12, b=8'h34; pulse start again with a=8'hFF, b=8'hFF during RUN and during DONE, and change the a/b inputs mid-RUN -> single done, sum=8'h46, second request ignored.
- Start a=8'hAA, b=8'h55, ci=1 and assert rst at RUN cycle 4 -> no done pulse, sum=8'h00, co=0, busy=0 next cycle; a new start afterwards -> sum=8'h00, co=1, z=1.
- Hold start high with randomized operands for 1000 operations -> every result equals a+b+ci and done pulses are exactly 10 cycles apart.
